// File: rtl/outputs_edit_buffer.sv
// outputs_edit_buffer
//   Holds a WIDTH-bit shadow word. The word is either loaded whole from
//   intercepted input data or edited one bit at a time by queued commands.
//   On commit, all queued edits are drained and the shadow word is then
//   published on out_buf with a valid/ready handshake. Because of this,
//   each committed word reflects a complete set of edits.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   in_valid/in_data      whole-word load, accepted when in_ready
//   in_ready              idle and no edits pending
//   edit_valid/addr/val   edit command: mode 00 write val, 01 toggle,
//   edit_mode             1x no-op (still consumes a FIFO slot)
//   edit_ready            idle and edit FIFO not full
//   commit                single-cycle publish request (ignored when busy)
//   out_valid/out_ready   output handshake for out_buf
//   out_buf               last committed word
//   busy                  not idle
//   addr_err              sticky, an applied edit addressed a bit >= WIDTH
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | accept loads/edits, apply one queued edit per cycle
// ST_DRAIN   | no new input, apply remaining edits, then publish
// ST_PRESENT | out_valid held until out_ready
module outputs_edit_buffer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(WIDTH),
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic              edit_valid,
  input  logic [ADDR_W-1:0] edit_addr,
  input  logic              edit_val,
  input  logic [1:0]        edit_mode,
  output logic              edit_ready,
  input  logic              commit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_buf,
  output logic              busy,
  output logic              addr_err
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 3;
  localparam logic [ADDR_W:0] WIDTH_LIM = (ADDR_W + 1)'(WIDTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  logic [1:0]        state;
  logic [WIDTH-1:0]  shadow;
  logic [WIDTH-1:0]  shadow_nxt;
  logic              err_set;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              load;
  logic [ADDR_W-1:0] head_addr;
  logic              head_val;
  logic [1:0]        head_mode;
  logic              head_in_range;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  assign {head_addr, head_val, head_mode} = mem[rd_ptr[PTR_W-2:0]];
  assign head_in_range = ({1'b0, head_addr} < WIDTH_LIM);

  assign in_ready   = (state == ST_IDLE) && fifo_empty;
  assign edit_ready = (state == ST_IDLE) && !fifo_full;
  assign busy       = (state != ST_IDLE);

  assign load = in_valid && in_ready;
  assign push = edit_valid && edit_ready;
  assign pop  = ((state == ST_IDLE) || (state == ST_DRAIN)) && !fifo_empty;

  // A load requires an empty FIFO, so a load and a pop never coincide.
  // An edit pushed together with a load therefore lands on the loaded word.
  always_comb begin
    shadow_nxt = shadow;
    err_set    = 1'b0;
    if (load) begin
      shadow_nxt = in_data;
    end else if (pop && !head_mode[1]) begin
      if (head_in_range) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (ADDR_W'(i) == head_addr) begin
            shadow_nxt[i] = head_mode[0] ? ~shadow[i] : head_val;
          end
        end
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-2:0]] <= {edit_addr, edit_val, edit_mode};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      out_buf   <= '0;
      out_valid <= 1'b0;
      addr_err  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (err_set) addr_err <= 1'b1;
      if (push)    wr_ptr   <= wr_ptr + 1'b1;
      if (pop)     rd_ptr   <= rd_ptr + 1'b1;
      case (state)
        ST_IDLE: begin
          if (commit) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            out_buf   <= shadow;
            out_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outputs_edit_buffer.sv
// Bench for outputs_edit_buffer. The same stimulus drives a WIDTH=32 and a
// WIDTH=24 instance. A queue-based reference model predicts every output
// after every clock edge.
module tb_outputs_edit_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        edit_valid;
  logic [4:0]  edit_addr;
  logic        edit_val;
  logic [1:0]  edit_mode;
  logic        commit;
  logic        out_ready;

  logic        a_in_ready, a_edit_ready, a_out_valid, a_busy, a_addr_err;
  logic [31:0] a_out_buf;
  logic        b_in_ready, b_edit_ready, b_out_valid, b_busy, b_addr_err;
  logic [23:0] b_out_buf;

  outputs_edit_buffer #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .edit_valid(edit_valid), .edit_addr(edit_addr), .edit_val(edit_val),
    .edit_mode(edit_mode), .edit_ready(a_edit_ready),
    .commit(commit), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_buf(a_out_buf), .busy(a_busy), .addr_err(a_addr_err)
  );

  outputs_edit_buffer #(.WIDTH(24), .DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data[23:0]), .in_ready(b_in_ready),
    .edit_valid(edit_valid), .edit_addr(edit_addr), .edit_val(edit_val),
    .edit_mode(edit_mode), .edit_ready(b_edit_ready),
    .commit(commit), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_buf(b_out_buf), .busy(b_busy), .addr_err(b_addr_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model. Index 0 models the 32-bit instance, index 1 the 24-bit one.
  typedef struct {
    logic [4:0] addr;
    logic       val;
    logic [1:0] mode;
  } edit_t;

  edit_t       q[$];
  int          m_ph;          // 0 idle, 1 draining, 2 presenting
  logic        m_ov;
  logic [31:0] m_sh  [2];
  logic [31:0] m_ob  [2];
  logic        m_err [2];
  int          wid   [2] = '{32, 24};
  logic [31:0] saved;

  task automatic model_reset();
    q.delete();
    m_ph = 0;
    m_ov = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_sh[k] = '0; m_ob[k] = '0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_apply(input edit_t e);
    for (int k = 0; k < 2; k++) begin
      if (e.mode < 2) begin
        if (int'(e.addr) < wid[k]) begin
          if (e.mode == 0) m_sh[k][e.addr] = e.val;
          else             m_sh[k][e.addr] = ~m_sh[k][e.addr];
        end else begin
          m_err[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge();
    edit_t e;
    bit    ld, ps;
    case (m_ph)
      0: begin
        ld = in_valid && (q.size() == 0);
        ps = edit_valid && (q.size() < 4);
        if (q.size() > 0) begin
          e = q.pop_front();
          model_apply(e);
        end
        if (ld) begin
          m_sh[0] = in_data;
          m_sh[1] = {8'h00, in_data[23:0]};
        end
        if (ps) q.push_back('{addr: edit_addr, val: edit_val, mode: edit_mode});
        if (commit) m_ph = 1;
      end
      1: begin
        if (q.size() > 0) begin
          e = q.pop_front();
          model_apply(e);
        end else begin
          m_ob[0] = m_sh[0];
          m_ob[1] = m_sh[1];
          m_ov    = 1'b1;
          m_ph    = 2;
        end
      end
      default: begin
        if (out_ready) begin
          m_ov = 1'b0;
          m_ph = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic e_inr, e_edr, e_busy;
    e_inr  = (m_ph == 0) && (q.size() == 0);
    e_edr  = (m_ph == 0) && (q.size() < 4);
    e_busy = (m_ph != 0);
    chk({tag, ".a_in_ready"},   32'(a_in_ready),   32'(e_inr));
    chk({tag, ".a_edit_ready"}, 32'(a_edit_ready), 32'(e_edr));
    chk({tag, ".a_busy"},       32'(a_busy),       32'(e_busy));
    chk({tag, ".a_out_valid"},  32'(a_out_valid),  32'(m_ov));
    chk({tag, ".a_out_buf"},    a_out_buf,         m_ob[0]);
    chk({tag, ".a_addr_err"},   32'(a_addr_err),   32'(m_err[0]));
    chk({tag, ".b_in_ready"},   32'(b_in_ready),   32'(e_inr));
    chk({tag, ".b_edit_ready"}, 32'(b_edit_ready), 32'(e_edr));
    chk({tag, ".b_busy"},       32'(b_busy),       32'(e_busy));
    chk({tag, ".b_out_valid"},  32'(b_out_valid),  32'(m_ov));
    chk({tag, ".b_out_buf"},    {8'h00, b_out_buf}, m_ob[1]);
    chk({tag, ".b_addr_err"},   32'(b_addr_err),   32'(m_err[1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_data = '0; edit_valid = 1'b0; edit_addr = '0;
    edit_val = 1'b0; edit_mode = 2'b00; commit = 1'b0; out_ready = 1'b0;
  endtask

  task automatic set_edit(input logic [4:0] a, input logic v, input logic [1:0] m);
    edit_valid = 1'b1; edit_addr = a; edit_val = v; edit_mode = m;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    model_reset();
    #2;
    check_all("reset");
    #10;
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset");

    // Load then commit with no edits.
    in_valid = 1'b1; in_data = 32'hA5A5_0000;
    step("load1");
    in_valid = 1'b0; commit = 1'b1;
    step("commit1");
    chk("c1_not_yet_valid", 32'(a_out_valid), 32'd0);
    commit = 1'b0;
    step("drain1");
    chk("c1_valid", 32'(a_out_valid), 32'd1);
    chk("c1_buf", a_out_buf, 32'hA5A5_0000);
    chk("c1_busy", 32'(a_busy), 32'd1);
    step("hold1a");
    step("hold1b");
    out_ready = 1'b1;
    step("accept1");
    out_ready = 1'b0;
    chk("c1_idle", 32'(a_busy), 32'd0);

    // Bit edits on a zero word; addr 31 is out of range for the 24-bit instance.
    in_valid = 1'b1; in_data = 32'h0;
    step("load2");
    in_valid = 1'b0;
    set_edit(5'd3, 1'b1, 2'b00);  step("e_w3");
    set_edit(5'd3, 1'b0, 2'b01);  step("e_t3");
    set_edit(5'd31, 1'b1, 2'b00); step("e_w31");
    edit_valid = 1'b0; commit = 1'b1;
    step("commit2");
    commit = 1'b0;
    step("drain2");
    step("drain2b");
    chk("c2_buf", a_out_buf, 32'h8000_0000);
    chk("c2_valid", 32'(a_out_valid), 32'd1);
    chk("c2_b_err", 32'(b_addr_err), 32'd1);
    chk("c2_a_err", 32'(a_addr_err), 32'd0);

    // While presenting, commit, loads and edits are all ignored.
    commit = 1'b1; in_valid = 1'b1; in_data = $urandom;
    set_edit(5'd0, 1'b1, 2'b00);
    step("present_ignore");
    chk("c3_in_ready", 32'(a_in_ready), 32'd0);
    chk("c3_edit_ready", 32'(a_edit_ready), 32'd0);
    chk("c3_buf_stable", a_out_buf, 32'h8000_0000);
    commit = 1'b0; in_valid = 1'b0; edit_valid = 1'b0;
    out_ready = 1'b1;
    step("accept2");
    out_ready = 1'b0;
    saved = $urandom;
    in_valid = 1'b1; in_data = saved;
    step("load3");
    in_valid = 1'b0; commit = 1'b1;
    step("commit3");
    commit = 1'b0;
    step("drain3");
    chk("c3_buf", a_out_buf, saved);
    out_ready = 1'b1;
    step("accept3");
    out_ready = 1'b0;

    // Out-of-range edit on the narrow instance, followed by valid edits.
    in_valid = 1'b1; in_data = 32'h0000_FF00;
    step("load4");
    in_valid = 1'b0;
    set_edit(5'd30, 1'b1, 2'b00); step("e_w30");
    set_edit(5'd2, 1'b0, 2'b01);  step("e_t2");
    edit_valid = 1'b0; commit = 1'b1;
    step("commit4");
    commit = 1'b0;
    step("drain4");
    chk("c4_a_buf", a_out_buf, 32'h4000_FF04);
    chk("c4_b_buf", {8'h00, b_out_buf}, 32'h0000_FF04);
    chk("c4_b_err_sticky", 32'(b_addr_err), 32'd1);
    out_ready = 1'b1;
    step("accept4");
    out_ready = 1'b0;

    // Reset asserted between edges while draining with an edit still queued.
    set_edit(5'd5, 1'b1, 2'b00);
    step("e_w5");
    set_edit(5'd6, 1'b1, 2'b00); commit = 1'b1;
    step("commit5");
    drive_idle();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("c5_ov", 32'(a_out_valid), 32'd0);
    chk("c5_buf", a_out_buf, 32'd0);
    chk("c5_busy", 32'(a_busy), 32'd0);
    chk("c5_in_ready", 32'(a_in_ready), 32'd1);
    #10;
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst2");
    step("post_rst3");

    // Randomized traffic on all inputs.
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) == 0);
      in_data    = $urandom;
      edit_valid = $urandom_range(0, 1);
      edit_mode  = 2'($urandom_range(0, 3));
      edit_val   = $urandom_range(0, 1);
      edit_addr  = edit_mode[1] ? 5'($urandom_range(0, 23)) : 5'($urandom_range(0, 31));
      commit     = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 2) == 0);
      step("rand");
    end
    drive_idle();
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) step("flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
